// File: rtl/mac_pkg.sv
// Shared types, constants and fixed-point arithmetic for the 2x2 systolic MAC array.
// MAC_SATURATE_EN selects saturating multiply/accumulate; otherwise both wrap modulo 2^WIDTH.
package mac_pkg;

    localparam int unsigned WIDTH           = 16;
    localparam int unsigned FRAC_WIDTH      = 8;
    localparam int unsigned BLOCK_SIZE      = 2;
    localparam int unsigned INNER_DIMENSION = 64;
    localparam int unsigned CHUNK_SIZE      = BLOCK_SIZE * BLOCK_SIZE;
    localparam int unsigned LAST_CYCLE      = INNER_DIMENSION + 2 * BLOCK_SIZE - 3;

    typedef logic signed [WIDTH-1:0] data_t;

    // Output tile, C00 in the least significant lane.
    typedef struct packed {
        data_t c11;
        data_t c10;
        data_t c01;
        data_t c00;
    } tile_t;

    localparam data_t DATA_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam data_t DATA_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic data_t sat_add(input data_t a, input data_t b);
        logic signed [WIDTH:0] s;
        data_t r;
        s = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        if (s[WIDTH] != s[WIDTH-1]) begin
            r = s[WIDTH] ? DATA_MIN : DATA_MAX;
        end else begin
            r = s[WIDTH-1:0];
        end
        return r;
    endfunction

    // Full-precision signed product, rescaled by FRAC_WIDTH, then reduced to WIDTH.
    function automatic data_t fxp_mul(input data_t a, input data_t b);
`ifdef MAC_SATURATE_EN
        logic signed [2*WIDTH-1:0] p;
        data_t r;
        p = ((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC_WIDTH;
        if (p[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){p[2*WIDTH-1]}}) begin
            r = p[2*WIDTH-1] ? DATA_MIN : DATA_MAX;
        end else begin
            r = p[WIDTH-1:0];
        end
        return r;
`else
        return WIDTH'(((2*WIDTH)'(a) * (2*WIDTH)'(b)) >>> FRAC_WIDTH);
`endif
    endfunction

    function automatic data_t fxp_add(input data_t a, input data_t b);
`ifdef MAC_SATURATE_EN
        return sat_add(a, b);
`else
        return a + b;
`endif
    endfunction

endpackage

// File: rtl/mac_array_if.sv
// Feed and result bundle between the matrix feeder/collector and the MAC array.
interface mac_array_if;
    import mac_pkg::*;

    data_t in_north0;
    data_t in_north1;
    data_t in_west0;
    data_t in_west2;
    logic  accumulator_done;
    logic  systolic_finish;
    tile_t out;

    modport master (
        output in_north0, in_north1, in_west0, in_west2,
        input  accumulator_done, systolic_finish, out
    );

    modport slave (
        input  in_north0, in_north1, in_west0, in_west2,
        output accumulator_done, systolic_finish, out
    );

endinterface

// File: rtl/mac_pe.sv
// One processing element: accumulates north*west and forwards both operands one cycle later.
module mac_pe
    import mac_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  en,
    input  data_t north,
    input  data_t west,
    output data_t north_q,
    output data_t west_q,
    output data_t acc_next_c
);

    data_t acc;

    always_comb begin
        acc_next_c = fxp_add(acc, fxp_mul(north, west));
    end

    // Registers freeze once the tile is complete so late feeds cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc     <= '0;
            north_q <= '0;
            west_q  <= '0;
        end else if (en) begin
            acc     <= acc_next_c;
            north_q <= north;
            west_q  <= west;
        end
    end

endmodule

// File: rtl/mac_array.sv
// Output-stationary 2x2 systolic MAC array: PE wiring, feed counter, done/finish flags, tile snapshot.
// Build option: MAC_SATURATE_EN (see mac_pkg).
module mac_array
    import mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_acc,
    mac_array_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(LAST_CYCLE + 2);

    data_t north_in [CHUNK_SIZE];
    data_t west_in  [CHUNK_SIZE];
    data_t north_q  [CHUNK_SIZE];
    data_t west_q   [CHUNK_SIZE];
    data_t acc_next [CHUNK_SIZE];

    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic             finish_q;
    tile_t            tile_q;
    logic             run_c;
    logic             last_c;

    // PE1 borrows PE0's west, PE2 borrows PE0's north, PE3 takes from PE1/PE2.
    assign north_in[0] = bus.in_north0;
    assign north_in[1] = bus.in_north1;
    assign north_in[2] = north_q[0];
    assign north_in[3] = north_q[1];
    assign west_in[0]  = bus.in_west0;
    assign west_in[1]  = west_q[0];
    assign west_in[2]  = bus.in_west2;
    assign west_in[3]  = west_q[2];

    for (genvar i = 0; i < CHUNK_SIZE; i++) begin : g_pe
        mac_pe u_pe (
            .clk        (clk),
            .rst        (rst),
            .clear      (reset_acc),
            .en         (run_c),
            .north      (north_in[i]),
            .west       (west_in[i]),
            .north_q    (north_q[i]),
            .west_q     (west_q[i]),
            .acc_next_c (acc_next[i])
        );
    end

    always_comb begin
        run_c  = !(done_q || finish_q);
        last_c = run_c && (cnt == CNT_W'(LAST_CYCLE));
    end

    // Snapshot takes the next-state accumulators so PE3's final term is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            done_q   <= 1'b0;
            finish_q <= 1'b0;
            tile_q   <= '0;
        end else if (reset_acc) begin
            cnt      <= '0;
            done_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            done_q   <= last_c;
            finish_q <= finish_q || done_q;
            if (run_c) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (last_c) begin
                tile_q <= '{c11: acc_next[3], c10: acc_next[2],
                            c01: acc_next[1], c00: acc_next[0]};
            end
        end
    end

    assign bus.accumulator_done = done_q;
    assign bus.systolic_finish  = finish_q;
    assign bus.out              = tile_q;

endmodule

// File: tb/tb_mac_array.sv
// Directed self-checking bench for mac_array with hand-computed tiles and flag timing.
module tb_mac_array;

    localparam int VEC = 80;

    logic clk = 1'b0;
    logic rst;
    logic reset_acc;

    int checks = 0;
    int errors = 0;

    logic [15:0] w0_v [VEC];
    logic [15:0] n0_v [VEC];
    logic [15:0] w2_v [VEC];
    logic [15:0] n1_v [VEC];

    logic [63:0] exp_ovf;

    mac_array_if bus ();

    mac_array dut (
        .clk       (clk),
        .rst       (rst),
        .reset_acc (reset_acc),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero all feeds; optionally put non-zero junk on every feed after the tile has finished.
    task automatic clear_vec(input bit junk);
        for (int i = 0; i < VEC; i++) begin
            w0_v[i] = '0;
            n0_v[i] = '0;
            w2_v[i] = '0;
            n1_v[i] = '0;
            if (junk && i >= 68) begin
                w0_v[i] = 16'h0100;
                n0_v[i] = 16'h0100;
                w2_v[i] = 16'h0100;
                n1_v[i] = 16'h0100;
            end
        end
    endtask

    task automatic load_terms(input logic [15:0] w0a, input logic [15:0] w0b,
                              input logic [15:0] n0a, input logic [15:0] n0b,
                              input logic [15:0] w2a, input logic [15:0] w2b,
                              input logic [15:0] n1a, input logic [15:0] n1b);
        w0_v[0] = w0a; w0_v[1] = w0b;
        n0_v[0] = n0a; n0_v[1] = n0b;
        w2_v[1] = w2a; w2_v[2] = w2b;
        n1_v[1] = n1a; n1_v[2] = n1b;
    endtask

    task automatic pulse_clear();
        reset_acc = 1'b1;
        step();
    endtask

    // Edge 0 is the first rising edge with both resets low.
    task automatic run_tile(input string tag, input logic [63:0] exp_tile,
                            input int abort_e, input int exp_done);
        int done_at  = -1;
        int fin_at   = -1;
        int done_cnt = 0;
        rst = 1'b0;
        for (int e = 0; e < exp_done + 12; e++) begin
            reset_acc     = (e == abort_e);
            bus.in_west0  = (e < VEC) ? w0_v[e] : 16'h0000;
            bus.in_north0 = (e < VEC) ? n0_v[e] : 16'h0000;
            bus.in_west2  = (e < VEC) ? w2_v[e] : 16'h0000;
            bus.in_north1 = (e < VEC) ? n1_v[e] : 16'h0000;
            step();
            if (bus.accumulator_done) begin
                done_cnt++;
                if (done_at < 0) done_at = e;
            end
            if (bus.systolic_finish && fin_at < 0) fin_at = e;
        end
        reset_acc = 1'b0;
        check({tag, " done_edge"}, 64'(done_at), 64'(exp_done));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " finish_edge"}, 64'(fin_at), 64'(exp_done + 1));
        check({tag, " tile"}, bus.out, exp_tile);
    endtask

    initial begin
        rst           = 1'b1;
        reset_acc     = 1'b0;
        bus.in_west0  = '0;
        bus.in_north0 = '0;
        bus.in_west2  = '0;
        bus.in_north1 = '0;
        step();
        step();
        check("rst out", bus.out, 64'h0);
        check("rst done", 64'(bus.accumulator_done), 64'h0);
        check("rst finish", 64'(bus.systolic_finish), 64'h0);

        // Basic tile: C00=8.0 C01=7.0 C10=20.0 C11=15.0
        clear_vec(1'b1);
        load_terms(16'h0200, 16'h0100, 16'h0200, 16'h0400,
                   16'h0400, 16'h0300, 16'h0300, 16'h0100);
        run_tile("basic", 64'h0F00_1400_0700_0800, -1, 65);

        reset_acc = 1'b1;
        step();
        step();
        check("hold_clear done", 64'(bus.accumulator_done), 64'h0);
        check("hold_clear finish", 64'(bus.systolic_finish), 64'h0);
        check("hold_clear out kept", bus.out, 64'h0F00_1400_0700_0800);

        // Swapped operands: C00=8.0 C01=20.0 C10=7.0 C11=15.0
        clear_vec(1'b1);
        load_terms(16'h0200, 16'h0400, 16'h0200, 16'h0100,
                   16'h0300, 16'h0100, 16'h0400, 16'h0300);
        run_tile("swapped", 64'h0F00_0700_1400_0800, -1, 65);

        // -1.0 * 2.0 accumulated 64 times in PE0 lands exactly on -128.0
        pulse_clear();
        clear_vec(1'b1);
        for (int i = 0; i < 64; i++) begin
            w0_v[i] = 16'hFF00;
            n0_v[i] = 16'h0200;
        end
        run_tile("negative", 64'h0000_0000_0000_8000, -1, 65);

        // Product overflow in PE0/PE2, accumulator overflow in PE3
        pulse_clear();
        clear_vec(1'b1);
        w0_v[0] = 16'h7F00;
        n0_v[0] = 16'h0200;
        w2_v[1] = 16'h4000;
        w2_v[2] = 16'h4000;
        n1_v[1] = 16'h0100;
        n1_v[2] = 16'h0100;
`ifdef MAC_SATURATE_EN
        exp_ovf = 64'h7FFF_7FFF_7F00_7FFF;
`else
        exp_ovf = 64'h8000_8000_7F00_FE00;
`endif
        run_tile("overflow", exp_ovf, -1, 65);

        rst       = 1'b1;
        reset_acc = 1'b1;
        step();
        check("rst+clear out", bus.out, 64'h0);
        check("rst+clear done", 64'(bus.accumulator_done), 64'h0);
        check("rst+clear finish", 64'(bus.systolic_finish), 64'h0);
        reset_acc = 1'b0;

        // Clear pulsed mid-run: counter restarts on edge 31, done lands 65 edges later
        clear_vec(1'b0);
        load_terms(16'h0200, 16'h0100, 16'h0200, 16'h0400,
                   16'h0400, 16'h0300, 16'h0300, 16'h0100);
        run_tile("abort30", 64'h0, 30, 96);

        // Clear on the final accumulation edge wins over the done pulse
        pulse_clear();
        clear_vec(1'b0);
        load_terms(16'h0200, 16'h0100, 16'h0200, 16'h0400,
                   16'h0400, 16'h0300, 16'h0300, 16'h0100);
        run_tile("abort_last", 64'h0, 65, 131);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_array.md
# mac_array

Output-stationary 2×2 systolic multiply-accumulate block for signed fixed-point matrix multiplication; it computes one BLOCK_SIZE×BLOCK_SIZE output tile of C = A·B over INNER_DIMENSION terms. It sits inside the matrix-multiply datapath. An upstream feeder streams skewed A rows (west) and B columns (north). A downstream collector takes the packed tile once `systolic_finish` rises.

## Interface
- WIDTH, 16: data/accumulator width, two's complement.
- FRAC_WIDTH, 8: fractional bits (Q8.8 default).
- BLOCK_SIZE, 2: tile edge. The port list below is fixed for 2.
- INNER_DIMENSION, 64: number of product terms per output.
- CHUNK_SIZE, 4: outputs per tile. Must equal BLOCK_SIZE².
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- reset_acc  in  1  synchronous clear of accumulators, counter and flags. Held high means held clear.
- in_north0  in  WIDTH  B column 0 feed, enters PE0.
- in_north1  in  WIDTH  B column 1 feed, enters PE1, one cycle behind column 0.
- in_west0  in  WIDTH  A row 0 feed, enters PE0.
- in_west2  in  WIDTH  A row 1 feed, enters PE2, one cycle behind row 0.
- accumulator_done  out  1  one-cycle pulse when the final term reaches PE3.
- systolic_finish  out  1  level; tile in `out` is valid.
- out  out  WIDTH*CHUNK_SIZE  packed tile: [WIDTH-1:0]=C00 (PE0), next C01 (PE1), C10 (PE2), top C11 (PE3).

## Operation
- PE grid: PE0(0,0), PE1(0,1), PE2(1,0), PE3(1,1).
- Each PE: acc += (north × west), then forwards north down and west right through registers.
- PE1 takes its west operand from PE0's west register. PE2 takes its north operand from PE0's north register. PE3 takes north from PE1 and west from PE2.
- Product: full 2·WIDTH signed, arithmetic shift right by FRAC_WIDTH, truncate to WIDTH. Accumulation wraps modulo 2^WIDTH.
- Feed cycle counter starts at 0 on the first edge after `rst` or `reset_acc` deasserts and counts every edge.
- PE0 consumes terms on edges 0..N-1. PE1/PE2 consume on 1..N. PE3 consumes on 2..N+1 (N = INNER_DIMENSION).
- Zeros fed outside the valid window contribute nothing.
- On the edge of PE3's final accumulation (counter = N+2·BLOCK_SIZE-3):
  - `accumulator_done` pulses for one cycle.
  - `out` registers a snapshot of all four accumulators.
- `systolic_finish` rises on the following edge and holds until `rst`/`reset_acc`.
- After finish, the counter stops and the accumulators freeze. Feeds are ignored until `reset_acc`.

## Timing
- Reset (`rst`): all accumulators, pipeline registers and counter = 0. `out` = 0, `accumulator_done` = 0, `systolic_finish` = 0.
- `reset_acc` has the same effect as `rst` except that `out` keeps its last snapshot. `rst` has priority.
- Latency: `accumulator_done` is visible in cycle N+2·BLOCK_SIZE-2 after the first feed edge; `systolic_finish` follows one cycle later.
- `reset_acc` asserted in the same cycle as the final accumulation: the clear wins, and no done pulse or finish occurs.
- `rst` or `reset_acc` mid-operation: the computation is aborted and the counter restarts at 0 after release.

## Configuration
- MAC_SATURATE_EN defined: the product truncation and the accumulator add saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Undefined: both wrap modulo 2^WIDTH.

## Structure
- Shared package `mac_pkg`:
  - fixed-point multiply/shift function;
  - saturating-add function;
  - derived constant LAST_CYCLE = INNER_DIMENSION+2·BLOCK_SIZE-3.
- One sub-module `mac_pe`:
  - operand registers, accumulator, `reset_acc`/`rst` handling;
  - instantiated four times.
- Top: wiring, counter, done/finish logic, output snapshot.

## Test plan
- `rst` high 1 cycle: all outputs = 0; after release, no `systolic_finish` before cycle N+2·BLOCK_SIZE-1.
- Feeds, with N=64 and zeros thereafter:
  - west0 = 0x0200, 0x0100;
  - north0 = 0x0200, 0x0400;
  - one cycle later, west2 = 0x0400, 0x0300 and north1 = 0x0300, 0x0100.
  - Required: out = 64'h0F00_1400_0700_0800, `accumulator_done` pulse at cycle 66, `systolic_finish` high from 67.
- After finish, assert `reset_acc` and hold it: accumulators and flags = 0, `out` retained. Re-run with swapped operands and check the new tile.
- Negative operands: 0xFF00 × 0x0200 repeated 64 times in PE0 only → C00 wraps per the modulo rule. With MAC_SATURATE_EN defined → 0x8000.
- `reset_acc` pulsed at cycle 30 mid-run: no done at 66. Counter restarts and done occurs 66 cycles after release.
- `rst` and `reset_acc` asserted together after a finish: `out` = 0.
